// File: rtl/aha_clock_gate_ctrl_if.sv
// Handshake and ICG control bundle between the power manager and the clock-gate sequencer.
// The master side is the power manager / domain; the slave side is the controller.
interface aha_clock_gate_ctrl_if;
  logic       SLEEP_REQ;
  logic       IDLE;
  logic       TEST_MODE;
  logic       CG_E;
  logic       CG_TE;
  logic       SLEEP_ACK;
  logic [1:0] STATE;

  modport master (
    output SLEEP_REQ,
    output IDLE,
    output TEST_MODE,
    input  CG_E,
    input  CG_TE,
    input  SLEEP_ACK,
    input  STATE
  );

  modport slave (
    input  SLEEP_REQ,
    input  IDLE,
    input  TEST_MODE,
    output CG_E,
    output CG_TE,
    output SLEEP_ACK,
    output STATE
  );
endinterface

// File: rtl/aha_clock_gate_ctrl.sv
// Sequences the E/TE pins of an ICG cell: gates the domain clock after a stable idle
// period on SLEEP_REQ, and re-enables it with a settle interval before dropping ACK.
module aha_clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  aha_clock_gate_ctrl_if.slave  cg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       cg_e_reg, cg_e_next;
  logic       ack_reg, ack_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= RUN;
      cnt_reg   <= 8'd0;
      cg_e_reg  <= 1'b1;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cg_e_reg  <= cg_e_next;
      ack_reg   <= ack_next;
    end
  end

  // CG_E and SLEEP_ACK are updated only on the transitions so they stay glitch-free registers.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cg_e_next  = cg_e_reg;
    ack_next   = ack_reg;
    case (state_reg)
      RUN: begin
        if (cg.SLEEP_REQ) begin
          state_next = DRAIN;
          cnt_next   = 8'd0;
        end
      end
      DRAIN: begin
        if (!cg.SLEEP_REQ) begin
          state_next = RUN;
        end else if (!cg.IDLE) begin
          cnt_next = 8'd0;
        end else if (cnt_reg == IDLE_LAST) begin
          state_next = GATED;
          cg_e_next  = 1'b0;
          ack_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      GATED: begin
        if (!cg.SLEEP_REQ) begin
          cg_e_next = 1'b1;
          if (WAKE_CYCLES == 0) begin
            state_next = RUN;
            ack_next   = 1'b0;
          end else begin
            state_next = WAKE;
            cnt_next   = 8'd0;
          end
        end
      end
      WAKE: begin
        // REQ is deliberately ignored here; a premature re-raise is picked up in RUN.
        if (cnt_reg == WAKE_LAST) begin
          state_next = RUN;
          ack_next   = 1'b0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign cg.CG_E      = cg_e_reg;
  assign cg.SLEEP_ACK = ack_reg;
  assign cg.STATE     = state_reg;
  assign cg.CG_TE     = cg.TEST_MODE;

endmodule

// File: tb/tb_aha_clock_gate_ctrl.sv
// Randomized and directed bench for aha_clock_gate_ctrl: two instances (default and corner
// parameters) are driven in lockstep and compared every edge against a behavioural model.
module tb_aha_clock_gate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aha_clock_gate_ctrl_if if0 ();
  aha_clock_gate_ctrl_if if1 ();

  aha_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut0 (
    .CLK   (clk),
    .RESET (rst),
    .cg    (if0)
  );

  aha_clock_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0)) dut1 (
    .CLK   (clk),
    .RESET (rst),
    .cg    (if1)
  );

  always #5 clk = ~clk;

  // Behavioural ICG on dut0 so test mode can be seen actually running the gated clock.
  logic en_latch = 1'b0;
  logic gclk;
  int   gclk_edges = 0;
  always @(clk or if0.CG_E or if0.CG_TE) if (!clk) en_latch = if0.CG_E | if0.CG_TE;
  assign gclk = clk & en_latch;
  always @(posedge gclk) gclk_edges++;

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Model: gated flag, idle streak (-1 when not draining), remaining wake edges.
  int ic [2] = '{4, 1};
  int wc [2] = '{2, 0};
  bit m_gated  [2];
  int m_streak [2];
  int m_wake   [2];

  function automatic void model_reset(input int k);
    m_gated[k]  = 1'b0;
    m_streak[k] = -1;
    m_wake[k]   = 0;
  endfunction

  function automatic void model_edge(input int k, input bit r, input bit q, input bit i);
    if (r) begin
      model_reset(k);
    end else if (m_wake[k] > 0) begin
      m_wake[k] = m_wake[k] - 1;
    end else if (m_gated[k]) begin
      if (!q) begin
        m_gated[k] = 1'b0;
        m_wake[k]  = wc[k];
      end
    end else if (m_streak[k] >= 0) begin
      if (!q) m_streak[k] = -1;
      else if (!i) m_streak[k] = 0;
      else begin
        m_streak[k] = m_streak[k] + 1;
        if (m_streak[k] == ic[k]) begin
          m_gated[k]  = 1'b1;
          m_streak[k] = -1;
        end
      end
    end else if (q) begin
      m_streak[k] = 0;
    end
  endfunction

  function automatic int exp_state(input int k);
    if (m_wake[k] > 0) return 3;
    if (m_gated[k]) return 2;
    if (m_streak[k] >= 0) return 1;
    return 0;
  endfunction

  function automatic int exp_cg_e(input int k);
    return m_gated[k] ? 0 : 1;
  endfunction

  function automatic int exp_ack(input int k);
    return (m_gated[k] || m_wake[k] > 0) ? 1 : 0;
  endfunction

  task automatic step(input bit r, input bit q, input bit i, input bit t);
    @(negedge clk);
    rst = r;
    if0.SLEEP_REQ = q; if0.IDLE = i; if0.TEST_MODE = t;
    if1.SLEEP_REQ = q; if1.IDLE = i; if1.TEST_MODE = t;
    @(posedge clk);
    model_edge(0, r, q, i);
    model_edge(1, r, q, i);
    #1;
    n_step++;
    $display("step %0d rst=%0b req=%0b idle=%0b tm=%0b | d0 st=%0d e=%0b ack=%0b te=%0b | d1 st=%0d e=%0b ack=%0b te=%0b",
             n_step, r, q, i, t, if0.STATE, if0.CG_E, if0.SLEEP_ACK, if0.CG_TE,
             if1.STATE, if1.CG_E, if1.SLEEP_ACK, if1.CG_TE);
    check($sformatf("d0_state@%0d", n_step), int'(if0.STATE), exp_state(0));
    check($sformatf("d0_cg_e@%0d", n_step), int'(if0.CG_E), exp_cg_e(0));
    check($sformatf("d0_ack@%0d", n_step), int'(if0.SLEEP_ACK), exp_ack(0));
    check($sformatf("d0_cg_te@%0d", n_step), int'(if0.CG_TE), int'(t));
    check($sformatf("d1_state@%0d", n_step), int'(if1.STATE), exp_state(1));
    check($sformatf("d1_cg_e@%0d", n_step), int'(if1.CG_E), exp_cg_e(1));
    check($sformatf("d1_ack@%0d", n_step), int'(if1.SLEEP_ACK), exp_ack(1));
    check($sformatf("d1_cg_te@%0d", n_step), int'(if1.CG_TE), int'(t));
  endtask

  // Steps with fixed req/idle until dut0's ACK reaches want; returns edges taken (bounded).
  task automatic edges_until_ack0(input bit q, input bit want, output int n);
    n = 0;
    do begin
      step(1'b0, q, 1'b1, 1'b0);
      n++;
    end while (if0.SLEEP_ACK !== want && n < 20);
  endtask

  initial begin
    int n;
    int g0;
    bit q;
    bit i;
    bit t;
    bit r;
    bit idle_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    model_reset(0);
    model_reset(1);

    // Reset held with REQ=1, then DRAIN on the first released edge.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("post_reset_drain", int'(if0.STATE), 1);

    // Nominal gate and wake latency on the default instance.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    edges_until_ack0(1'b1, 1'b1, n);
    check("gate_latency", n, 5);
    edges_until_ack0(1'b0, 1'b0, n);
    check("wake_latency", n, 3);

    // Idle restart pattern during DRAIN.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, idle_pat[k], 1'b0);
      if (k == 6) check("idle_restart_not_yet", int'(if0.CG_E), 1);
    end
    check("idle_restart_gated", int'(if0.CG_E), 0);

    // Test mode while gated: the ICG output runs only with TE set.
    g0 = gclk_edges;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("gated_no_clock", gclk_edges - g0, 0);
    g0 = gclk_edges;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("test_mode_clock", gclk_edges - g0, 3);
    check("test_mode_still_gated", int'(if0.STATE), 2);

    // Reset while gated with REQ still high.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("reset_gated_cg_e", int'(if0.CG_E), 1);

    // Abort after two idle cycles in DRAIN.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_run", int'(if0.STATE), 0);

    // Protocol violation: REQ re-raised during WAKE.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with sticky REQ, mostly-idle domain and rare resets.
    q = 1'b0;
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 7) == 0) q = ~q;
      i = ($urandom_range(0, 9) < 8);
      t = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(r, q, i, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
